// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, derived sync-window bounds and output bundle type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_TOTAL   = 800;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_TOTAL   = 525;

   // Sync pulses start right after the front porch and last SYNC clocks/lines.
   localparam int unsigned DEF_HS_LO = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int unsigned DEF_HS_HI = DEF_HS_LO + DEF_H_SYNC - 1;
   localparam int unsigned DEF_VS_LO = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int unsigned DEF_VS_HI = DEF_VS_LO + DEF_V_SYNC - 1;

   // Registered per-position outputs, grouped so they reset and update as one word.
   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       video_on;
      logic [9:0] pixel_x;
      logic [9:0] pixel_y;
      logic       frame_start;
      logic       vblank_start;
   } sync_out_t;

   // Idle/blank value: syncs inactive (high), everything else low.
   localparam sync_out_t SYNC_OUT_IDLE = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

endpackage

// File: rtl/vga_sync_gen_if.sv
// Position-in / timing-out bundle between an upstream H/V counter pair and the sync generator.
// Latency: n/a (wires only).
// Backpressure: none; positions are sampled every pixel clock.
interface vga_sync_gen_if;

   logic [15:0] H_Counter_Value;
   logic [15:0] V_Counter_Value;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        frame_start;
   logic        vblank_start;
   logic [7:0]  frame_count;
   logic        range_err;

   // Upstream counter side: drives the position, observes timing.
   modport master (
      output H_Counter_Value, V_Counter_Value,
      input  hsync, vsync, video_on, pixel_x, pixel_y,
      input  frame_start, vblank_start, frame_count, range_err
   );

   // Sync generator side: consumes the position, produces timing.
   modport slave (
      input  H_Counter_Value, V_Counter_Value,
      output hsync, vsync, video_on, pixel_x, pixel_y,
      output frame_start, vblank_start, frame_count, range_err
   );

endinterface

// File: rtl/vga_window_cmp.sv
// Inclusive window compare: in_window = LO <= value <= HI on a 16-bit unsigned input.
// Latency: combinational.
// Backpressure: none.
module vga_window_cmp #(
   parameter int unsigned LO = 0,
   parameter int unsigned HI = 0
) (
   input  logic [15:0] value,
   output logic        in_window
);

   logic lo_ok;
   logic hi_ok;

   // Bounds at the edge of the 16-bit range are always met; skip the compare there.
   generate
      if (LO == 0) begin : g_lo_open
         assign lo_ok = 1'b1;
      end else begin : g_lo_cmp
         assign lo_ok = (value >= 16'(LO));
      end

      if (HI >= 65535) begin : g_hi_open
         assign hi_ok = 1'b1;
      end else begin : g_hi_cmp
         assign hi_ok = (value <= 16'(HI));
      end
   endgenerate

   assign in_window = lo_ok & hi_ok;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/blank decoder: turns an upstream (H,V) position into syncs, pixel coords and frame pulses.
// Latency: 1 clock from sampled H/V to every output.
// Backpressure: none; a held (stalled) position keeps outputs steady and never re-fires pulses.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_TOTAL   = DEF_H_TOTAL,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_TOTAL   = DEF_V_TOTAL
) (
   input  logic           clk_25MHz,
   input  logic           rst_n,
   vga_sync_gen_if.slave  bus
);

   localparam int unsigned HS_LO = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_HI = HS_LO + H_SYNC - 1;
   localparam int unsigned VS_LO = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_HI = VS_LO + V_SYNC - 1;

   logic [15:0] h;
   logic [15:0] v;
   logic        h_in_sync;
   logic        v_in_sync;
   logic        h_in_vis;
   logic        v_in_vis;
   logic        h_in_range;
   logic        v_in_range;
   logic        in_range;
   logic        at_origin;
   logic        at_vblank;
   logic        origin_q;
   logic        vblank_q;
   logic [7:0]  frame_count_q;
   logic        range_err_q;
   sync_out_t   nxt;
   sync_out_t   out_q;

   assign h = bus.H_Counter_Value;
   assign v = bus.V_Counter_Value;

   vga_window_cmp #(.LO(HS_LO), .HI(HS_HI))         u_h_sync  (.value(h), .in_window(h_in_sync));
   vga_window_cmp #(.LO(VS_LO), .HI(VS_HI))         u_v_sync  (.value(v), .in_window(v_in_sync));
   vga_window_cmp #(.LO(0),     .HI(H_VISIBLE - 1)) u_h_vis   (.value(h), .in_window(h_in_vis));
   vga_window_cmp #(.LO(0),     .HI(V_VISIBLE - 1)) u_v_vis   (.value(v), .in_window(v_in_vis));
   vga_window_cmp #(.LO(0),     .HI(H_TOTAL - 1))   u_h_range (.value(h), .in_window(h_in_range));
   vga_window_cmp #(.LO(0),     .HI(V_TOTAL - 1))   u_v_range (.value(v), .in_window(v_in_range));

   // Decode the next output word; out-of-range positions fall back to the idle word.
   always_comb begin
      nxt       = SYNC_OUT_IDLE;
      in_range  = h_in_range & v_in_range;
      at_origin = in_range && (h == 16'd0) && (v == 16'd0);
      at_vblank = in_range && (h == 16'd0) && (v == 16'(V_VISIBLE));
      if (in_range) begin
         nxt.hsync    = ~h_in_sync;
         nxt.vsync    = ~v_in_sync;
         nxt.video_on = h_in_vis & v_in_vis;
         if (h_in_vis && v_in_vis) begin
            nxt.pixel_x = h[9:0];
            nxt.pixel_y = v[9:0];
         end
         // Pulses fire only on entry, so a stalled position cannot repeat them.
         nxt.frame_start  = at_origin & ~origin_q;
         nxt.vblank_start = at_vblank & ~vblank_q;
      end
   end

   // Register outputs, edge-detect history, frame counter and sticky range error.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         out_q         <= SYNC_OUT_IDLE;
         origin_q      <= 1'b0;
         vblank_q      <= 1'b0;
         frame_count_q <= 8'd0;
         range_err_q   <= 1'b0;
      end else begin
         out_q         <= nxt;
         origin_q      <= at_origin;
         vblank_q      <= at_vblank;
         frame_count_q <= frame_count_q + {7'd0, nxt.frame_start};
         range_err_q   <= range_err_q | ~in_range;
      end
   end

   assign bus.hsync        = out_q.hsync;
   assign bus.vsync        = out_q.vsync;
   assign bus.video_on     = out_q.video_on;
   assign bus.pixel_x      = out_q.pixel_x;
   assign bus.pixel_y      = out_q.pixel_y;
   assign bus.frame_start  = out_q.frame_start;
   assign bus.vblank_start = out_q.vblank_start;
   assign bus.frame_count  = frame_count_q;
   assign bus.range_err    = range_err_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, default 96: hsync width, in clocks.
REQ-004 Parameter H_TOTAL, default 800: clocks per line; the counter range is 0..799.
REQ-005 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync width, in lines.
REQ-008 Parameter V_TOTAL, default 525: lines per frame; the counter range is 0..524.
REQ-009 clk_25MHz  in  1: the single pixel clock; every register samples on its rising edge.
REQ-010 rst_n  in  1: asynchronous, active-low reset.
REQ-011 H_Counter_Value  in  16: horizontal position from the upstream horizontal counter.
REQ-012 V_Counter_Value  in  16: vertical position from the upstream vertical counter.
REQ-013 hsync  out  1: horizontal sync, active-low.
REQ-014 vsync  out  1: vertical sync, active-low.
REQ-015 video_on  out  1: high while the position is in the visible area.
REQ-016 pixel_x  out  10: visible column; reads 0 when video_on is low.
REQ-017 pixel_y  out  10: visible row; reads 0 when video_on is low.
REQ-018 frame_start  out  1: one-clock pulse at position (0,0).
REQ-019 vblank_start  out  1: one-clock pulse at position (H=0, V=V_VISIBLE).
REQ-020 frame_count  out  8: count of completed frame starts; wraps 255 -> 0.
REQ-021 range_err  out  1: sticky flag, set when either input is out of range.

Function
REQ-022 Every output SHALL be registered, with exactly 1 clock of latency from the sampled H/V inputs.
REQ-023 hsync SHALL be 0 when H is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (default 656..751), and 1 otherwise.
REQ-024 vsync SHALL be 0 when V is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (default 490..491), and 1 otherwise.
REQ-025 video_on SHALL be 1 only when H < H_VISIBLE and V < V_VISIBLE.
REQ-026 When video_on is 1, pixel_x/pixel_y SHALL equal H[9:0]/V[9:0]; otherwise both SHALL be 0.
REQ-027 frame_start SHALL pulse for one clock when the inputs are H=0, V=0, and SHALL NOT re-pulse if (0,0) is held on consecutive clocks; this rule depends on edge detection of the (0,0) condition.
REQ-028 vblank_start SHALL follow the same edge rule as REQ-027, at H=0, V=V_VISIBLE.
REQ-029 frame_count SHALL increment in the same cycle that frame_start is asserted, with modulo-256 wrap.
REQ-030 When H >= H_TOTAL or V >= V_TOTAL: video_on=0, hsync=1, vsync=1, pixel_x=pixel_y=0, and no pulses are generated.
REQ-031 range_err SHALL be set on the first out-of-range sample and SHALL hold until reset.
REQ-032 Inputs may stall (value held while the upstream enable is low); outputs SHALL then stay steady and no pulse SHALL repeat.
REQ-033 Comparisons SHALL use the full 16-bit unsigned inputs; no truncation before range checks.

Reset
REQ-034 While rst_n=0, asynchronously: hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, vblank_start=0, frame_count=0, range_err=0, and the edge-detect history is cleared.
REQ-035 The first clock edge after rst_n rises SHALL register outputs from the current inputs.
REQ-036 If reset is asserted mid-frame, the outputs after release SHALL recover within 1 clock of valid inputs.
REQ-037 If (0,0) is present at the release of reset, frame_start SHALL pulse once.

Structure
REQ-038 The 640x480@60 timing constants and the derived sync-window bounds SHALL reside in the shared package vga_timing_pkg.
REQ-039 One sub-module, vga_window_cmp, SHALL be used: parameterised lo/hi bounds, 16-bit input, 1-bit in-window output; it is instantiated for hsync, vsync, and each visible-area check.
REQ-040 No other hierarchy SHALL be used; no memories and no additional clocks.

Verification
REQ-041 Hsync window: sweep H=655,656,751,752 with V=0 -> hsync=1,0,0,1, each 1 clock after input.
REQ-042 Vsync and visible area: V=489,490,491,492 with H=700 -> vsync=1,0,0,1 and video_on=0 throughout; H=639,V=479 -> video_on=1, pixel_x=639, pixel_y=479.
REQ-043 Frame pulses: run 3 full frames (800x525 stimulus) -> exactly 3 frame_start and 3 vblank_start pulses, frame_count=3; hold (0,0) for 5 clocks -> a single pulse.
REQ-044 Frame-count wrap: 256 frame starts -> frame_count rolls over to 0.
REQ-045 Out of range: H=800, V=10 -> range_err=1, hsync=1, vsync=1, video_on=0; range_err stays 1 after valid inputs resume; rst_n low clears it.
REQ-046 Reset mid-line: assert rst_n low at H=300, V=100 -> all outputs immediately take their reset values, without waiting for a clock; after release, video_on=1 on the next clock.
